// File: rtl/red_pitaya_dna_reader.sv
// Sequencer for the Xilinx DNA_PORT primitive: loads the device DNA and shifts it out MSB-first.
// Latency: dna_valid_o rises CLK_DIV*(2*DNA_W+1) clk_i cycles after the first LOAD cycle.
// Backpressure: none; start_i is honoured only in IDLE/DONE and dropped (not queued) while busy.
//
// Ports:
//   clk_i, rst_i          system clock, synchronous active-high reset
//   start_i               single-cycle re-read request
//   dna_clk_o             registered divided clock to DNA_PORT.CLK
//   dna_read_o            DNA_PORT.READ (parallel load)
//   dna_shift_o           DNA_PORT.SHIFT
//   dna_dout_i            DNA_PORT.DOUT
//   dna_value_o           last complete DNA word, bit DNA_W-1 = first bit shifted out
//   dna_valid_o           dna_value_o holds a completed read
//   busy_o                high while loading or shifting
module red_pitaya_dna_reader #(
  parameter int DNA_W      = 57,
  parameter int CLK_DIV    = 4,
  parameter bit AUTO_START = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             dna_clk_o,
  output logic             dna_read_o,
  output logic             dna_shift_o,
  input  logic             dna_dout_i,
  output logic [DNA_W-1:0] dna_value_o,
  output logic             dna_valid_o,
  output logic             busy_o
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (DNA_W > 1) ? $clog2(DNA_W) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DNA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [PW-1:0]    phase_cnt;   // cycles spent in the current half of dna_clk_o
  logic [BW-1:0]    bit_cnt;     // samples taken so far in SHIFT
  logic [DNA_W-1:0] shreg;
  logic             auto_pend;   // one-shot read request armed by reset
  logic             phase_end;
  logic [DNA_W-1:0] shreg_nxt;

  assign phase_end = (phase_cnt == PH_LAST);
  assign shreg_nxt = {shreg[DNA_W-2:0], dna_dout_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      phase_cnt   <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      auto_pend   <= AUTO_START;
      dna_clk_o   <= 1'b0;
      dna_read_o  <= 1'b0;
      dna_shift_o <= 1'b0;
      dna_value_o <= '0;
      dna_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          dna_clk_o <= 1'b0;
          if (start_i || auto_pend) begin
            state       <= LOAD;
            auto_pend   <= 1'b0;
            phase_cnt   <= '0;
            dna_read_o  <= 1'b1;
            busy_o      <= 1'b1;
            dna_valid_o <= 1'b0;
          end
        end

        // One full DNA clock period with READ held: low half, then high half.
        // READ/SHIFT swap on the falling edge so they only ever change while CLK is low.
        LOAD: begin
          if (phase_end) begin
            phase_cnt <= '0;
            if (!dna_clk_o) begin
              dna_clk_o <= 1'b1;
            end else begin
              dna_clk_o   <= 1'b0;
              dna_read_o  <= 1'b0;
              dna_shift_o <= 1'b1;
              bit_cnt     <= '0;
              state       <= SHIFT;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        // DOUT is captured at the end of each low half, just before the rising
        // edge that advances the primitive. The last sample gets no rising edge.
        SHIFT: begin
          if (phase_end) begin
            phase_cnt <= '0;
            if (!dna_clk_o) begin
              shreg <= shreg_nxt;
              if (bit_cnt == BIT_LAST) begin
                dna_value_o <= shreg_nxt;
                dna_valid_o <= 1'b1;
                dna_shift_o <= 1'b0;
                busy_o      <= 1'b0;
                state       <= DONE;
              end else begin
                dna_clk_o <= 1'b1;
                bit_cnt   <= bit_cnt + 1'b1;
              end
            end else begin
              dna_clk_o <= 1'b0;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_red_pitaya_dna_reader.sv
// Bench for red_pitaya_dna_reader: three instances (CLK_DIV=4 auto, CLK_DIV=1 auto,
// CLK_DIV=4 manual start), each driving its own behavioural DNA_PORT model.
// Expected words and completion cycles are queued at stimulus time and popped by monitors.
module tb_red_pitaya_dna_reader;

  localparam int W = 57;

  typedef struct {
    logic [W-1:0] val;
    int unsigned  cyc;
  } exp_t;

  logic        clk = 1'b0;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- instance A: CLK_DIV=4, AUTO_START=1 ----------------
  logic         rst_a = 1'b1, start_a = 1'b0;
  logic         a_clk, a_read, a_shift, a_dout, a_valid, a_busy;
  logic [W-1:0] a_value;
  logic [W-1:0] id_a = '0, msr_a = '0;

  red_pitaya_dna_reader #(.DNA_W(W), .CLK_DIV(4), .AUTO_START(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .start_i(start_a),
    .dna_clk_o(a_clk), .dna_read_o(a_read), .dna_shift_o(a_shift), .dna_dout_i(a_dout),
    .dna_value_o(a_value), .dna_valid_o(a_valid), .busy_o(a_busy)
  );

  always @(posedge a_clk) begin
    if (a_read) msr_a <= id_a;
    else if (a_shift) msr_a <= {msr_a[W-2:0], 1'b0};
  end
  assign a_dout = msr_a[W-1];

  // ---------------- instance B: CLK_DIV=1, AUTO_START=1 ----------------
  logic         rst_b = 1'b1, start_b = 1'b0;
  logic         b_clk, b_read, b_shift, b_dout, b_valid, b_busy;
  logic [W-1:0] b_value;
  logic [W-1:0] id_b = '0, msr_b = '0;

  red_pitaya_dna_reader #(.DNA_W(W), .CLK_DIV(1), .AUTO_START(1'b1)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .start_i(start_b),
    .dna_clk_o(b_clk), .dna_read_o(b_read), .dna_shift_o(b_shift), .dna_dout_i(b_dout),
    .dna_value_o(b_value), .dna_valid_o(b_valid), .busy_o(b_busy)
  );

  always @(posedge b_clk) begin
    if (b_read) msr_b <= id_b;
    else if (b_shift) msr_b <= {msr_b[W-2:0], 1'b0};
  end
  assign b_dout = msr_b[W-1];

  // ---------------- instance C: CLK_DIV=4, AUTO_START=0 ----------------
  logic         rst_c = 1'b1, start_c = 1'b0;
  logic         c_clk, c_read, c_shift, c_dout, c_valid, c_busy;
  logic [W-1:0] c_value;
  logic [W-1:0] id_c = '0, msr_c = '0;

  red_pitaya_dna_reader #(.DNA_W(W), .CLK_DIV(4), .AUTO_START(1'b0)) dut_c (
    .clk_i(clk), .rst_i(rst_c), .start_i(start_c),
    .dna_clk_o(c_clk), .dna_read_o(c_read), .dna_shift_o(c_shift), .dna_dout_i(c_dout),
    .dna_value_o(c_value), .dna_valid_o(c_valid), .busy_o(c_busy)
  );

  always @(posedge c_clk) begin
    if (c_read) msr_c <= id_c;
    else if (c_shift) msr_c <= {msr_c[W-2:0], 1'b0};
  end
  assign c_dout = msr_c[W-1];

  // ---------------- scoreboards / monitors ----------------
  exp_t qa[$], qb[$], qc[$];
  exp_t ea, eb, ec;
  logic a_vprev = 1'b0, b_vprev = 1'b0, c_vprev = 1'b0;

  // A: completion word/time, plus every dna_clk half must last exactly 4 cycles while busy
  int   a_run = 0, a_duty_err = 0;
  logic a_cprev = 1'b0, a_bprev = 1'b0;

  always @(negedge clk) begin
    if (a_valid && !a_vprev) begin
      if (qa.size() == 0) begin
        check("a_unexpected_valid", 64'd1, 64'd0);
      end else begin
        ea = qa.pop_front();
        check("a_value", 64'(a_value), 64'(ea.val));
        check("a_done_cycle", 64'(cyc), 64'(ea.cyc));
      end
    end
    a_vprev <= a_valid;
    if (a_busy && a_bprev) begin
      if (a_clk != a_cprev) begin
        if (a_run != 4) a_duty_err <= a_duty_err + 1;
        a_run <= 1;
      end else begin
        a_run <= a_run + 1;
      end
    end else begin
      a_run <= 1;
    end
    a_cprev <= a_clk;
    a_bprev <= a_busy;
  end

  // B: completion plus waveform statistics
  int   b_rd_edges = 0, b_sh_edges = 0, b_ovl = 0, b_tog_err = 0;
  logic b_cprev = 1'b0, b_bprev = 1'b0;

  always @(negedge clk) begin
    if (b_valid && !b_vprev) begin
      if (qb.size() == 0) begin
        check("b_unexpected_valid", 64'd1, 64'd0);
      end else begin
        eb = qb.pop_front();
        check("b_value", 64'(b_value), 64'(eb.val));
        check("b_done_cycle", 64'(cyc), 64'(eb.cyc));
      end
    end
    b_vprev <= b_valid;
    if (b_busy && b_bprev && (b_clk == b_cprev)) b_tog_err <= b_tog_err + 1;
    if (b_clk && !b_cprev && b_read) b_rd_edges <= b_rd_edges + 1;
    if (b_clk && !b_cprev && b_shift) b_sh_edges <= b_sh_edges + 1;
    if (b_read && b_shift) b_ovl <= b_ovl + 1;
    b_cprev <= b_clk;
    b_bprev <= b_busy;
  end

  always @(negedge clk) begin
    if (c_valid && !c_vprev) begin
      if (qc.size() == 0) begin
        check("c_unexpected_valid", 64'd1, 64'd0);
      end else begin
        ec = qc.pop_front();
        check("c_value", 64'(c_value), 64'(ec.val));
        check("c_done_cycle", 64'(cyc), 64'(ec.cyc));
      end
    end
    c_vprev <= c_valid;
  end

  task automatic wait_valid(input int which, input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      case (which)
        0:       seen = a_valid;
        1:       seen = b_valid;
        default: seen = c_valid;
      endcase
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: valid not seen within %0d cycles", name, budget);
    end
  endtask

  // ---------------- stimulus ----------------
  int unsigned load;
  int          c_idle_err;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_a_ctl", 64'({a_clk, a_read, a_shift, a_valid, a_busy}), 64'd0);
    check("rst_a_value", 64'(a_value), 64'd0);
    check("rst_c_ctl", 64'({c_clk, c_read, c_shift, c_valid, c_busy}), 64'd0);

    // Auto read after reset release, with an ignored start_i 100 cycles in
    id_a  = 57'h0823456789ABCDE;
    rst_a = 1'b0;
    load  = cyc + 1;
    qa.push_back('{val: id_a, cyc: load + 460});
    @(negedge clk);
    check("t1_busy", 64'({a_busy, a_read, a_clk}), 64'b110);
    while (cyc < load + 100) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("t3_busy_during", 64'(a_busy), 64'd1);
    wait_valid(0, 600, "t1_wait_valid");
    repeat (10) @(negedge clk);
    check("t3_not_queued", 64'({a_busy, a_clk, a_shift, a_valid}), 64'b0001);

    // Re-read from DONE with a new model value; old word held meanwhile
    id_a    = 57'h1FFFFFFFFFFFFFF;
    start_a = 1'b1;
    load    = cyc + 1;
    qa.push_back('{val: id_a, cyc: load + 460});
    @(negedge clk);
    start_a = 1'b0;
    check("t4_valid_drop", 64'({a_valid, a_busy}), 64'b01);
    check("t4_hold_early", 64'(a_value), 64'(57'h0823456789ABCDE));
    repeat (200) @(negedge clk);
    check("t4_hold_mid", 64'(a_value), 64'(57'h0823456789ABCDE));
    wait_valid(0, 600, "t4_wait_valid");

    // Reset 200 cycles into a read, then a clean automatic read
    id_a    = 57'h1A5A5A5A5A5A5A5;
    start_a = 1'b1;
    load    = cyc + 1;
    @(negedge clk);
    start_a = 1'b0;
    while (cyc < load + 200) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    check("t5_rst_ctl", 64'({a_clk, a_read, a_shift, a_valid, a_busy}), 64'd0);
    check("t5_rst_value", 64'(a_value), 64'd0);
    @(negedge clk);
    rst_a = 1'b0;
    load  = cyc + 1;
    qa.push_back('{val: id_a, cyc: load + 460});
    wait_valid(0, 600, "t5_wait_valid");
    check("a_duty", 64'(a_duty_err), 64'd0);

    // CLK_DIV=1 waveform
    id_b  = 57'h13579BDF02468AC;
    rst_b = 1'b0;
    load  = cyc + 1;
    qb.push_back('{val: id_b, cyc: load + 115});
    wait_valid(1, 300, "t2_wait_valid");
    @(negedge clk);
    check("t2_read_edges", 64'(b_rd_edges), 64'd1);
    check("t2_shift_edges", 64'(b_sh_edges), 64'd56);
    check("t2_overlap", 64'(b_ovl), 64'd0);
    check("t2_toggle", 64'(b_tog_err), 64'd0);

    // AUTO_START=0: idle until start_i
    id_c       = 57'h0F0E0D0C0B0A090;
    rst_c      = 1'b0;
    c_idle_err = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (c_busy || c_clk || c_read || c_valid) c_idle_err++;
    end
    check("t6_idle", 64'(c_idle_err), 64'd0);
    start_c = 1'b1;
    load    = cyc + 1;
    qc.push_back('{val: id_c, cyc: load + 460});
    @(negedge clk);
    start_c = 1'b0;
    check("t6_busy", 64'(c_busy), 64'd1);
    wait_valid(2, 600, "t6_wait_valid");

    repeat (5) @(negedge clk);
    check("qa_empty", 64'(qa.size()), 64'd0);
    check("qb_empty", 64'(qb.size()), 64'd0);
    check("qc_empty", 64'(qc.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
